// File: rtl/uart_rx.sv
// UART receiver: idle-high line, one start bit, DATA_BITS LSB-first data, STOP_BITS stop bits, mid-bit sampling.
// Optional macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the samples around its sample point.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int TICK_NBR  = 100
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_data_rx,
   output logic [DATA_BITS-1:0] o_data_rx,
   output logic                 o_valid_rx,
   output logic                 o_frame_err,
   output logic                 o_busy_rx
);

   localparam int TICK_W = $clog2(TICK_NBR);
   localparam int BIT_W  = $clog2(DATA_BITS) + 1;
   localparam int STOP_W = 2;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_NBR - 1);
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(TICK_NBR / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      RECOVER
   } state_e;

   state_e               state_q,    state_d;
   logic                 sync1_q,    sync1_d;
   logic                 sync2_q,    sync2_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
   logic                 err_q,      err_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [DATA_BITS-1:0] data_q,     data_d;
   logic                 valid_q,    valid_d;
   logic                 ferr_q,     ferr_d;
   logic                 busy_q,     busy_d;
   logic                 rx_s;
   logic                 bit_s;

   assign rx_s = sync2_q;

`ifdef UART_RX_MAJORITY_EN
   // Three-tap median of rx_s: the whole FSM runs one cycle late, centred on rx_h1_q.
   logic rx_h1_q, rx_h1_d;
   logic rx_h2_q, rx_h2_d;

   assign rx_h1_d = rx_s;
   assign rx_h2_d = rx_h1_q;
   assign bit_s   = (rx_s & rx_h1_q) | (rx_s & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
   assign bit_s = rx_s;
`endif

   always_comb begin
      // NOTE: every _d is given its hold value first, so no path through the case infers a latch.
      sync1_d    = i_data_rx;
      sync2_d    = sync1_q;
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      err_d      = err_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      ferr_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bit_s) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end

         START: begin
            if (tick_cnt_q == TICK_MID) begin
               tick_cnt_d = '0;
               if (!bit_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
               tick_cnt_d = '0;
               shift_d    = {bit_s, shift_q[DATA_BITS-1:1]};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d    = STOP;
                  stop_cnt_d = '0;
                  err_d      = 1'b0;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
               tick_cnt_d = '0;
               err_d      = err_q | ~bit_s;
               stop_cnt_d = stop_cnt_q + 1'b1;
               // Leave at the mid-stop sample so a following start edge is not missed.
               if (stop_cnt_q == STOP_LAST) begin
                  if (err_d) begin
                     ferr_d  = 1'b1;
                     state_d = RECOVER;
                  end else begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                     state_d = IDLE;
                  end
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
         end

         RECOVER: begin
            if (bit_s) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: the datapath registers are reset too, so a discarded partial word never reaches o_data_rx.
         state_q    <= IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
         err_q      <= 1'b0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         rx_h1_q    <= 1'b1;
         rx_h2_q    <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         err_q      <= err_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         busy_q     <= busy_d;
`ifdef UART_RX_MAJORITY_EN
         rx_h1_q    <= rx_h1_d;
         rx_h2_q    <= rx_h2_d;
`endif
      end
   end

   assign o_data_rx   = data_q;
   assign o_valid_rx  = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy_rx   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a line driver pushes the expected word (or frame error) per frame,
// and a monitor pops and compares whenever the receiver strobes o_valid_rx or o_frame_err.
module tb_uart_rx;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam int TICK_NBR  = 100;
   localparam int HALF      = TICK_NBR / 2;
   localparam int NB        = 1 + DATA_BITS + STOP_BITS;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
   localparam int LAT = HALF + (DATA_BITS + STOP_BITS) * TICK_NBR + 4;
`else
   localparam bit MAJ = 1'b0;
   localparam int LAT = HALF + (DATA_BITS + STOP_BITS) * TICK_NBR + 3;
`endif

   typedef struct {
      bit                   is_err;
      logic [DATA_BITS-1:0] data;
      int                   start_cyc;
   } exp_t;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 rx    = 1'b1;
   logic [DATA_BITS-1:0] o_data_rx;
   logic                 o_valid_rx;
   logic                 o_frame_err;
   logic                 o_busy_rx;

   int                   cyc = 0;
   int                   n_vec = 0;
   int                   n_miss = 0;
   exp_t                 sb[$];
   logic [DATA_BITS-1:0] last_good = '0;

   uart_rx #(
      .DATA_BITS(DATA_BITS),
      .STOP_BITS(STOP_BITS),
      .TICK_NBR (TICK_NBR)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_data_rx  (rx),
      .o_data_rx  (o_data_rx),
      .o_valid_rx (o_valid_rx),
      .o_frame_err(o_frame_err),
      .o_busy_rx  (o_busy_rx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                        input int unsigned tol = 0);
      n_vec++;
      if ($isunknown(act) || act > exp + tol || act + tol < exp) begin
         n_miss++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (+/- %0d) at cycle %0d",
                  name, act, act, exp, tol, cyc);
      end
   endtask

   // Line level j cycles after the start edge: frame bit j/TICK_NBR, optionally flipped for one cycle.
   function automatic bit line_at(input logic [NB-1:0] fb, input int glitch_j, input int j);
      return fb[j / TICK_NBR] ^ (j == glitch_j);
   endfunction

   // Value the receiver should see for frame bit b: the level at the bit centre, or a 3-cycle vote.
   function automatic bit bit_value(input logic [NB-1:0] fb, input int glitch_j, input int b);
      int c = b * TICK_NBR + HALF;
      int ones;
      if (!MAJ) return line_at(fb, glitch_j, c);
      ones = int'(line_at(fb, glitch_j, c - 1)) + int'(line_at(fb, glitch_j, c))
           + int'(line_at(fb, glitch_j, c + 1));
      return ones >= 2;
   endfunction

   task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit stop_bad, input int glitch_j);
      logic [NB-1:0] fb;
      exp_t          e;
      fb       = {{STOP_BITS{~stop_bad}}, d, 1'b0};
      e.is_err = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) e.data[i] = bit_value(fb, glitch_j, 1 + i);
      for (int s = 0; s < STOP_BITS; s++)
         if (!bit_value(fb, glitch_j, 1 + DATA_BITS + s)) e.is_err = 1'b1;
      @(negedge clk);
      e.start_cyc = cyc;
      sb.push_back(e);
      for (int j = 0; j < NB * TICK_NBR; j++) begin
         if (j > 0) @(negedge clk);
         rx = line_at(fb, glitch_j, j);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx = 1'b1;
      end
   endtask

   // Monitor: pops one expectation per strobe.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (o_valid_rx || o_frame_err)) begin
         check("valid_err_exclusive", 32'(o_valid_rx & o_frame_err), 0);
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_pulse: valid=%b frame_err=%b data=0x%0h, required no pulse at cycle %0d",
                     o_valid_rx, o_frame_err, o_data_rx, cyc);
         end else begin
            e = sb.pop_front();
            check("pulse_is_frame_err", 32'(o_frame_err), 32'(e.is_err));
            if (e.is_err) begin
               check("err_keeps_data", 32'(o_data_rx), 32'(last_good));
            end else begin
               check("rx_data", 32'(o_data_rx), 32'(e.data));
               last_good = e.data;
            end
            check("latency", cyc - e.start_cyc, LAT, 1);
         end
      end
   end

   initial begin : stim
      int busy_len;
      int gap;
      bit bad;
      logic [DATA_BITS-1:0] d;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", 32'(o_data_rx), 0);
      check("rst_valid", 32'(o_valid_rx), 0);
      check("rst_frame_err", 32'(o_frame_err), 0);
      check("rst_busy", 32'(o_busy_rx), 0);
      rst_n = 1'b1;
      idle(20);
      check("idle_busy", 32'(o_busy_rx), 0);

      // Single clean frame, then back-to-back 00 / FF with no idle gap
      send_frame(8'hA3, 1'b0, -1);
      idle(50);
      send_frame(8'h00, 1'b0, -1);
      send_frame(8'hFF, 1'b0, -1);
      idle(200);

      // Ten-cycle low glitch: rejected at the mid-start sample
      busy_len = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx = 1'b0;
         if (o_busy_rx) busy_len++;
      end
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         rx = 1'b1;
         if (o_busy_rx) busy_len++;
      end
      check("start_glitch_busy_len", busy_len, 52, 3);

      // Bad stop bit, line held low: one frame error, no restart until the line is high again
      send_frame(8'h5A, 1'b1, -1);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rx = 1'b0;
      end
      check("recover_busy_while_low", 32'(o_busy_rx), 1);
      idle(200);
      check("recover_back_to_idle", 32'(o_busy_rx), 0);
      check("recover_data_kept", 32'(o_data_rx), 32'(last_good));
      send_frame(8'h3C, 1'b0, -1);
      idle(100);

      // Reset in the middle of data bit 4 of a frame of ones
      for (int j = 0; j < 5 * TICK_NBR + HALF; j++) begin
         @(negedge clk);
         rx = (j >= TICK_NBR);
      end
      check("busy_mid_frame", 32'(o_busy_rx), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_data", 32'(o_data_rx), 0);
      check("midrst_valid", 32'(o_valid_rx), 0);
      check("midrst_frame_err", 32'(o_frame_err), 0);
      check("midrst_busy", 32'(o_busy_rx), 0);
      repeat (3) @(negedge clk);
      rx        = 1'b1;
      rst_n     = 1'b1;
      last_good = '0;
      idle(600);
      check("post_rst_busy", 32'(o_busy_rx), 0);
      send_frame(8'hC5, 1'b0, -1);
      idle(100);

      // One-cycle high glitch at the bit-2 sample point of 8'h00
      send_frame(8'h00, 1'b0, HALF + 3 * TICK_NBR);
      idle(100);

      // Randomized frames, gaps and stop-bit errors
      for (int k = 0; k < 20; k++) begin
         d   = DATA_BITS'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         send_frame(d, bad, -1);
         if (bad)                           gap = TICK_NBR + int'($urandom_range(0, 200));
         else if ($urandom_range(0, 3) == 0) gap = 0;
         else                               gap = int'($urandom_range(1, 300));
         idle(gap);
      end

      for (int i = 0; i < 2 * NB * TICK_NBR && sb.size() != 0; i++) idle(1);
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
